code_run_encoder: RTL and testbench
===================================

Name: code_run_encoder

Overview:
- Downstream consumer of the 8-bit classification code stream produced by the counter/case stage (codes such as 10/20/30, one per cycle).
- Run-length encodes the stream into (value, count) pairs for a narrower logging/trace port.
- Input side is a valid/ready consumer; output side is a single registered pair slot with valid/ready.

Parameters:
- RUN_W, 8, width of the run count; MAX_RUN = 2^RUN_W - 1.

Ports:
- clock  in  1  global clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream code valid
- in_ready  out  1  block accepts a code this cycle
- in_data  in  8  upstream code
- flush  in  1  level request: emit and close the open run
- out_valid  out  1  pair slot holds a pair
- out_ready  in  1  downstream takes the pair
- out_data  out  8  run value
- out_count  out  RUN_W  run length, 1..MAX_RUN
- stat_pairs  out  16  pairs emitted (only with CODE_RUN_STATS_EN)

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Internal state: run_open (1), run_val (8), run_cnt (RUN_W), plus the output slot.
- Reset values: out_valid=0, out_data=0, out_count=0, run_open=0, run_val=0, run_cnt=0, stat_pairs=0.
- Slot free: slot_free = !out_valid || out_ready.
- Input ready: in_ready = slot_free && !flush.
- Accept: accept = in_valid && in_ready.
- Accept with run_open=0: open the run with run_val=in_data, run_cnt=1. No emit.
- Accept, run open, in_data==run_val, run_cnt<MAX_RUN: run_cnt += 1. No emit.
- Accept, run open, and either in_data!=run_val or run_cnt==MAX_RUN: emit (run_val, run_cnt) to the slot, then restart the run with (in_data, 1).
- Flush with run_open and slot_free: emit (run_val, run_cnt), set run_open=0. No input is accepted during flush.
- Flush with run_open=0: no-op. Flush is held by the requester until it observes out_valid for the flushed pair, or knows no run was open.
- Emit: out_valid=1 and out_data/out_count load on the next edge. Latency from the terminating beat's accept edge to out_valid is 1 cycle.
- Slot update: slot is cleared (out_valid=0) when out_ready=1 and there is no emit that cycle. A simultaneous drain and emit replaces the slot contents with no bubble.
- out_data/out_count are stable while out_valid=1 and out_ready=0.
- Sustained throughput is 1 code/cycle while out_ready=1.
- Count arithmetic: run_cnt never wraps. Saturation at MAX_RUN forces a split, so the next pair for the same value starts at 1.
- Reset mid-run: the open run and the pending pair are discarded; nothing is emitted after release.
- in_valid with flush=1: the code is not accepted (in_ready=0) and must be held by upstream.

Optional Feature:
- Macro: CODE_RUN_STATS_EN.
- Defined: the stat_pairs port exists. It is a 16-bit counter that increments on every emit, wraps at 65535 to 0, and resets to 0.
- Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Package code_run_pkg: RUN_W default, MAX_RUN constant, and typedef run_pair_t {logic[7:0] val; logic[RUN_W-1:0] cnt}.
- Sub-module run_pair_slot (one-entry registered valid/ready holding register for run_pair_t): load and drain inputs, with load-while-drain supported.
- Run tracking logic stays in the top.

Test Plan:
- Inputs 10,10,10,20 (out_ready=1), then flush → (10,3) one cycle after the 20 is accepted; (20,1) one cycle after flush; run closed.
- RUN_W=4, 17 consecutive 30s, then flush → (30,15) then (30,2); out_count never exceeds 15.
- Pair pending with out_ready=0 and a differing code arrives → in_ready=0, slot unchanged over 5 cycles; out_ready=1 → drain, code accepted the same cycle.
- Alternating 10,20,10,20 with out_ready=1 → pairs (10,1),(20,1),(10,1) on consecutive cycles, no bubbles, in_ready stays 1.
- reset asserted mid-run (run 20,cnt=4) with a pair pending → out_valid=0 immediately; after release, flush emits nothing.
- CODE_RUN_STATS_EN defined, 3 emits → stat_pairs=3; reset → 0.

Source files
------------

// File: rtl/code_run_pkg.sv
// Shared constants and the (value, count) pair type for the code run-length encoder.
package code_run_pkg;

    localparam int unsigned RUN_W_DEFAULT   = 8;
    localparam int unsigned MAX_RUN_DEFAULT = (2 ** RUN_W_DEFAULT) - 1;

    typedef struct packed {
        logic [7:0]               val;
        logic [RUN_W_DEFAULT-1:0] cnt;
    } run_pair_t;

endpackage

// File: rtl/run_pair_slot.sv
// One-entry registered valid/ready holding register for a run pair.
// A load in the same cycle as a drain replaces the contents without a bubble.
module run_pair_slot
    import code_run_pkg::*;
#(
    parameter type pair_t = run_pair_t
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  pair_t load_pair,
    input  logic  drain,
    output logic  valid,
    output pair_t pair
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pair  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pair  <= load_pair;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/code_run_encoder.sv
// Run-length encodes an 8-bit code stream into (value, count) pairs.
// Defining CODE_RUN_STATS_EN adds the 16-bit stat_pairs emit counter port.
module code_run_encoder
    import code_run_pkg::*;
#(
    parameter int unsigned RUN_W = RUN_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [RUN_W-1:0] out_count
`ifdef CODE_RUN_STATS_EN
    ,
    output logic [15:0]      stat_pairs
`endif
);

    typedef struct packed {
        logic [7:0]       val;
        logic [RUN_W-1:0] cnt;
    } pair_t;

    localparam logic [RUN_W-1:0] MAX_RUN = '1;

    logic             slot_free, accept, extend, flush_emit, emit;
    logic             run_open_q, run_open_d;
    logic [7:0]       run_val_q, run_val_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    pair_t            emit_pair, slot_pair;

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = slot_free && !flush;
    assign accept     = in_valid && in_ready;
    // A saturated run is split even when the code repeats, so counts never wrap.
    assign extend     = run_open_q && (in_data == run_val_q) && (run_cnt_q != MAX_RUN);
    assign flush_emit = flush && run_open_q && slot_free;
    assign emit       = (accept && run_open_q && !extend) || flush_emit;
    assign emit_pair  = {run_val_q, run_cnt_q};

    always_comb begin
        run_open_d = run_open_q;
        run_val_d  = run_val_q;
        run_cnt_d  = run_cnt_q;
        if (accept) begin
            run_open_d = 1'b1;
            run_val_d  = in_data;
            run_cnt_d  = extend ? run_cnt_q + 1'b1 : RUN_W'(1);
        end else if (flush_emit) begin
            run_open_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_open_q <= 1'b0;
            run_val_q  <= '0;
            run_cnt_q  <= '0;
        end else begin
            run_open_q <= run_open_d;
            run_val_q  <= run_val_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    run_pair_slot #(
        .pair_t(pair_t)
    ) u_slot (
        .clock    (clock),
        .reset    (reset),
        .load     (emit),
        .load_pair(emit_pair),
        .drain    (out_ready),
        .valid    (out_valid),
        .pair     (slot_pair)
    );

    assign out_data  = slot_pair.val;
    assign out_count = slot_pair.cnt;

`ifdef CODE_RUN_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else if (emit) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_pairs = stat_q;
`endif

endmodule

// File: tb/tb_code_run_encoder.sv
// Bench for code_run_encoder (RUN_W=4): pair-level reference model plus directed vectors.
module tb_code_run_encoder;

    localparam int RUN_W   = 4;
    localparam int MAX_RUN = (2 ** RUN_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'd0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic [RUN_W-1:0] out_count;
`ifdef CODE_RUN_STATS_EN
    logic [15:0]      stat_pairs;
`endif

    code_run_encoder #(
        .RUN_W(RUN_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
`ifdef CODE_RUN_STATS_EN
        ,
        .stat_pairs(stat_pairs)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int got[$];
    int got_cyc[$];
    int exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pr(input int v, input int c);
        return v * 256 + c;
    endfunction

    // Reference model: open run (value, length) and the single output slot.
    logic       m_open = 1'b0;
    logic [7:0] m_val = 8'd0;
    int         m_cnt = 0;
    logic       m_valid = 1'b0;
    int         m_data = 0;
    int         m_count = 0;
    int         m_stats = 0;
    logic       m_free, m_take, m_cont, m_close;

    assign m_free  = !m_valid || out_ready;
    assign m_take  = in_valid && m_free && !flush;
    assign m_cont  = m_take && m_open && (in_data == m_val) && (m_cnt < MAX_RUN);
    assign m_close = (m_take && m_open && !m_cont) || (flush && m_open && m_free);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_open  <= 1'b0;
            m_val   <= 8'd0;
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_data  <= 0;
            m_count <= 0;
            m_stats <= 0;
        end else begin
            if (m_take) begin
                m_open <= 1'b1;
                m_val  <= in_data;
                m_cnt  <= m_cont ? m_cnt + 1 : 1;
            end else if (flush && m_free) begin
                m_open <= 1'b0;
            end
            if (m_close) begin
                m_valid <= 1'b1;
                m_data  <= int'(m_val);
                m_count <= m_cnt;
                m_stats <= (m_stats + 1) % 65536;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            chk("rst_out_valid", int'(out_valid), 0);
        end else begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("in_ready", int'(in_ready), int'((!m_valid || out_ready) && !flush));
            if (m_valid) begin
                chk("out_data", int'(out_data), m_data);
                chk("out_count", int'(out_count), m_count);
            end
`ifdef CODE_RUN_STATS_EN
            chk("stat_pairs", int'(stat_pairs), m_stats);
`endif
            if (out_valid && out_ready) begin
                got.push_back(pr(int'(out_data), int'(out_count)));
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clock);
        #2;
    endtask

    task automatic expect_pairs(input string name);
        chk({name, "_npairs"}, got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            chk($sformatf("%s_pair%0d", name, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
        end
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #2;
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_count", int'(out_count), 0);
`ifdef CODE_RUN_STATS_EN
        chk("rst_stat_pairs", int'(stat_pairs), 0);
`endif
        reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        step(0, 8'd0, 0, 1);

        // 10,10,10,20 then flush
        repeat (3) step(1, 8'd10, 0, 1);
        step(1, 8'd20, 0, 1);
        chk("t1_valid_a", int'(out_valid), 1);
        chk("t1_data_a", int'(out_data), 10);
        chk("t1_count_a", int'(out_count), 3);
        step(0, 8'd0, 1, 1);
        chk("t1_valid_b", int'(out_valid), 1);
        chk("t1_data_b", int'(out_data), 20);
        chk("t1_count_b", int'(out_count), 1);
        step(0, 8'd0, 0, 1);
        chk("t1_drained", int'(out_valid), 0);
        step(0, 8'd0, 1, 1);
        chk("t1_flush_closed", int'(out_valid), 0);
        step(0, 8'd0, 0, 1);
        exp_q = '{pr(10, 3), pr(20, 1)};
        expect_pairs("t1");

        // 17 x 30 saturates at 15 and splits
        for (int i = 1; i <= 17; i++) begin
            step(1, 8'd30, 0, 1);
            if (i == 16) begin
                chk("t2_sat_valid", int'(out_valid), 1);
                chk("t2_sat_count", int'(out_count), 15);
            end
        end
        step(0, 8'd0, 1, 1);
        step(0, 8'd0, 0, 1);
        exp_q = '{pr(30, 15), pr(30, 2)};
        expect_pairs("t2");

        // Back-pressure: pending pair holds, differing code waits
        step(1, 8'd40, 0, 0);
        step(1, 8'd50, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'd60, 0, 0);
            chk("t3_hold_ready", int'(in_ready), 0);
            chk("t3_hold_data", int'(out_data), 40);
            chk("t3_hold_count", int'(out_count), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_ready_on_drain", int'(in_ready), 1);
        @(posedge clock);
        #2;
        chk("t3_next_data", int'(out_data), 50);
        step(0, 8'd0, 1, 1);
        chk("t3_flush_data", int'(out_data), 60);
        step(0, 8'd0, 0, 1);
        exp_q = '{pr(40, 1), pr(50, 1), pr(60, 1)};
        expect_pairs("t3");

        // Alternating codes: one pair per cycle, no bubbles
        step(1, 8'd10, 0, 1);
        chk("t4_ready0", int'(in_ready), 1);
        step(1, 8'd20, 0, 1);
        chk("t4_ready1", int'(in_ready), 1);
        step(1, 8'd10, 0, 1);
        chk("t4_ready2", int'(in_ready), 1);
        step(1, 8'd20, 0, 1);
        chk("t4_ready3", int'(in_ready), 1);
        step(0, 8'd0, 1, 1);
        step(0, 8'd0, 0, 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t4_gap%0d", i),
                (i < got_cyc.size()) ? got_cyc[i] - got_cyc[i-1] : -1, 1);
        end
        exp_q = '{pr(10, 1), pr(20, 1), pr(10, 1), pr(20, 1)};
        expect_pairs("t4");

        // Reset mid-run with a pair pending
        repeat (4) step(1, 8'd20, 0, 0);
        step(1, 8'd30, 0, 0);
        chk("t5_pending_valid", int'(out_valid), 1);
        chk("t5_pending_count", int'(out_count), 4);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("t5_async_clear", int'(out_valid), 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        step(0, 8'd0, 1, 1);
        chk("t5_flush_nothing", int'(out_valid), 0);
        step(0, 8'd0, 0, 1);
        chk("t5_still_empty", int'(out_valid), 0);
        exp_q.delete();
        expect_pairs("t5");

        // Three emits, then reset
        step(1, 8'd1, 0, 1);
        step(1, 8'd2, 0, 1);
        step(1, 8'd3, 0, 1);
        step(0, 8'd0, 1, 1);
        step(0, 8'd0, 0, 1);
`ifdef CODE_RUN_STATS_EN
        chk("t6_stat_three", int'(stat_pairs), 3);
`endif
        reset = 1'b1;
        #1;
`ifdef CODE_RUN_STATS_EN
        chk("t6_stat_reset", int'(stat_pairs), 0);
`endif
        @(posedge clock);
        #2;
        reset = 1'b0;
        exp_q = '{pr(1, 1), pr(2, 1), pr(3, 1)};
        expect_pairs("t6");

        step(0, 8'd0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
